// File: rtl/fetch_mem_arbiter_if.sv
// fetch_mem_arbiter_if
//   Bundles the requester and memory-side signals of fetch_mem_arbiter.
//   slave  : arbiter view. Requests and memRdata come in; grants,
//            responses and the memory command go out.
//   master : environment view (core pipeline plus memory), the mirror image.
//   Fetch  : fetchReq/fetchAddr/flush in, fetchGnt/fetchStall/fetchRvalid/
//            fetchRdata out.
//   Data   : dataReq/dataWe/dataBe/dataAddr/dataWdata in, dataGnt/
//            dataRvalid/dataRdata out.
//   Memory : memReq/memWe/memBe/memAddr/memWdata out, memRdata in.
interface fetch_mem_arbiter_if;
  logic        fetchReq;
  logic [31:0] fetchAddr;
  logic        flush;
  logic        fetchGnt;
  logic        fetchStall;
  logic        fetchRvalid;
  logic [31:0] fetchRdata;
  logic        dataReq;
  logic        dataWe;
  logic [3:0]  dataBe;
  logic [31:0] dataAddr;
  logic [31:0] dataWdata;
  logic        dataGnt;
  logic        dataRvalid;
  logic [31:0] dataRdata;
  logic        memReq;
  logic        memWe;
  logic [3:0]  memBe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [31:0] memRdata;

  modport slave (
    input  fetchReq, fetchAddr, flush,
    input  dataReq, dataWe, dataBe, dataAddr, dataWdata,
    input  memRdata,
    output fetchGnt, fetchStall, fetchRvalid, fetchRdata,
    output dataGnt, dataRvalid, dataRdata,
    output memReq, memWe, memBe, memAddr, memWdata
  );

  modport master (
    output fetchReq, fetchAddr, flush,
    output dataReq, dataWe, dataBe, dataAddr, dataWdata,
    output memRdata,
    input  fetchGnt, fetchStall, fetchRvalid, fetchRdata,
    input  dataGnt, dataRvalid, dataRdata,
    input  memReq, memWe, memBe, memAddr, memWdata
  );
endinterface

// File: rtl/fetch_mem_arbiter.sv
// fetch_mem_arbiter
//   Shares one single-ported synchronous memory between instruction fetch
//   and the load/store unit. At most one request is issued per cycle; data
//   normally wins, but fetch takes priority after STARVE_MAX consecutive
//   denied cycles. Reads are tracked through a MEM_LAT-deep tag pipeline so
//   read data is steered back to its owner; a flush kills in-flight fetch
//   reads.
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous, active-high reset
//     bus  : fetch_mem_arbiter_if.slave (fetch, data and memory signals)
//   Parameters:
//     MEM_LAT    : memory read latency in cycles (1..4)
//     STARVE_MAX : denied fetch cycles before fetch gets priority (1..15)
module fetch_mem_arbiter #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic                 clk,
  input logic                 rst,
  fetch_mem_arbiter_if.slave  bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]         starveCnt;
  logic [MEM_LAT-1:0] tagVld;
  logic [MEM_LAT-1:0] tagOwn;   // 0 = fetch, 1 = data
  logic               fetchEligible;
  logic               fetchGnt;
  logic               dataGnt;
  logic               memReq;
  logic               memWe;
  logic               tailVld;
  logic               tailOwn;

  // Grant selection; rst gates every grant so outputs are quiet in reset.
  always_comb begin
    fetchGnt      = 1'b0;
    dataGnt       = 1'b0;
    fetchEligible = bus.fetchReq & ~bus.flush & ~rst;
    if ((starveCnt == STARVE_LIM) && fetchEligible) begin
      fetchGnt = 1'b1;
    end else begin
      dataGnt  = bus.dataReq & ~rst;
      fetchGnt = fetchEligible & ~bus.dataReq;
    end
  end

  assign memReq       = fetchGnt | dataGnt;
  assign bus.fetchGnt = fetchGnt;
  assign bus.dataGnt  = dataGnt;
  assign bus.memReq   = memReq;
  assign bus.memWe    = memWe;
  assign bus.fetchStall = bus.fetchReq & ~fetchGnt & ~rst;

  always_comb begin
    memWe        = 1'b0;
    bus.memBe    = '0;
    bus.memAddr  = '0;
    bus.memWdata = '0;
    if (dataGnt) begin
      memWe        = bus.dataWe;
      bus.memBe    = bus.dataBe;
      bus.memAddr  = bus.dataAddr;
      bus.memWdata = bus.dataWdata;
    end else if (fetchGnt) begin
      bus.memBe    = '1;
      bus.memAddr  = bus.fetchAddr;
    end
  end

  // Counts consecutive denied fetch cycles; a flush with fetchReq holds it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starveCnt <= '0;
    end else if (!bus.fetchReq || fetchGnt) begin
      starveCnt <= '0;
    end else if (!bus.flush && (starveCnt != STARVE_LIM)) begin
      starveCnt <= starveCnt + 4'd1;
    end
  end

  // Stage 0 never needs a flush kill: fetch cannot be granted in a flush cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tagVld <= '0;
      tagOwn <= '0;
    end else begin
      tagVld[0] <= memReq & ~memWe;
      tagOwn[0] <= dataGnt;
      for (int unsigned i = 1; i < MEM_LAT; i++) begin
        tagVld[i] <= tagVld[i-1] & ~(bus.flush & ~tagOwn[i-1]);
        tagOwn[i] <= tagOwn[i-1];
      end
    end
  end

  assign tailVld = tagVld[MEM_LAT-1];
  assign tailOwn = tagOwn[MEM_LAT-1];

  // A fetch response arriving in a flush cycle belongs to the dead path.
  assign bus.fetchRvalid = tailVld & ~tailOwn & ~bus.flush;
  assign bus.dataRvalid  = tailVld & tailOwn;
  assign bus.fetchRdata  = bus.fetchRvalid ? bus.memRdata : '0;
  assign bus.dataRdata   = bus.dataRvalid ? bus.memRdata : '0;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
module tb_fetch_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetchReq, flush, dataReq, dataWe;
  logic [31:0] fetchAddr, dataAddr, dataWdata;
  logic [3:0]  dataBe;

  int unsigned total = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  always #5 clk = ~clk;

  fetch_mem_arbiter_if ifa();
  fetch_mem_arbiter_if ifb();

  fetch_mem_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dutA (.clk(clk), .rst(rst), .bus(ifa));
  fetch_mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dutB (.clk(clk), .rst(rst), .bus(ifb));

  assign ifa.fetchReq = fetchReq;  assign ifb.fetchReq = fetchReq;
  assign ifa.fetchAddr = fetchAddr; assign ifb.fetchAddr = fetchAddr;
  assign ifa.flush = flush;        assign ifb.flush = flush;
  assign ifa.dataReq = dataReq;    assign ifb.dataReq = dataReq;
  assign ifa.dataWe = dataWe;      assign ifb.dataWe = dataWe;
  assign ifa.dataBe = dataBe;      assign ifb.dataBe = dataBe;
  assign ifa.dataAddr = dataAddr;  assign ifb.dataAddr = dataAddr;
  assign ifa.dataWdata = dataWdata; assign ifb.dataWdata = dataWdata;

  // Memory model: fixed read latency per DUT, byte-enabled writes from DUT A.
  function automatic logic [31:0] minit(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

  logic [31:0] mem [0:1023];
  logic [31:0] rdA [0:1];
  logic [31:0] rdB [0:2];
  logic [31:0] wtmp;

  initial for (int i = 0; i < 1024; i++) mem[i] = minit(32'(i * 4));

  always @(posedge clk) begin
    if (ifa.memReq && ifa.memWe) begin
      wtmp = mem[ifa.memAddr[11:2]];
      for (int b = 0; b < 4; b++)
        if (ifa.memBe[b]) wtmp[b*8 +: 8] = ifa.memWdata[b*8 +: 8];
      mem[ifa.memAddr[11:2]] <= wtmp;
    end
    rdA[0] <= mem[ifa.memAddr[11:2]];
    rdA[1] <= rdA[0];
    rdB[0] <= mem[ifb.memAddr[11:2]];
    rdB[1] <= rdB[0];
    rdB[2] <= rdB[1];
  end

  assign ifa.memRdata = rdA[1];
  assign ifb.memRdata = rdB[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    fetchReq = 1'b0; dataReq = 1'b0; flush = 1'b0; dataWe = 1'b0;
    dataBe = 4'h0; dataWdata = '0;
  endtask

  task automatic idle(input int n);
    quiet();
    for (int i = 0; i < n; i++) nxt();
  endtask

  task automatic load(input logic [31:0] a);
    dataReq = 1'b1; dataWe = 1'b0; dataAddr = a; dataBe = 4'h0;
  endtask

  logic [31:0] e;

  initial begin
    // Reset with both requesters asserting.
    rst = 1'b1; quiet(); fetchAddr = '0; dataAddr = '0;
    fetchReq = 1'b1; dataReq = 1'b1;
    #3;
    chk("rst_fetchGnt", ifa.fetchGnt, 0);
    chk("rst_dataGnt", ifa.dataGnt, 0);
    chk("rst_stall", ifa.fetchStall, 0);
    chk("rst_memReq", ifa.memReq, 0);
    chk("rst_memAddr", ifa.memAddr, 0);
    @(negedge clk); rst = 1'b0; quiet();
    nxt();

    // Back-to-back fetch stream.
    fetchReq = 1'b1; fetchAddr = 32'h0; #3;
    chk("f0_gnt", ifa.fetchGnt, 1);
    chk("f0_stall", ifa.fetchStall, 0);
    chk("f0_memBe", ifa.memBe, 4'hF);
    chk("f0_memWe", ifa.memWe, 0);
    nxt(); fetchAddr = 32'h4; #3;
    chk("f1_gnt", ifa.fetchGnt, 1);
    chk("f1_memAddr", ifa.memAddr, 32'h4);
    nxt(); fetchAddr = 32'h8; #3;
    chk("f2_gnt", ifa.fetchGnt, 1);
    chk("f2_rvA", ifa.fetchRvalid, 1);
    chk("f2_rdA", ifa.fetchRdata, minit(32'h0));
    nxt(); fetchReq = 1'b0; #3;
    chk("f3_rdA", ifa.fetchRdata, minit(32'h4));
    chk("f3_rdB", ifb.fetchRdata, minit(32'h0));
    nxt(); #3;
    chk("f4_rdA", ifa.fetchRdata, minit(32'h8));
    chk("f4_rdB", ifb.fetchRdata, minit(32'h4));
    nxt(); #3;
    chk("f5_rvA", ifa.fetchRvalid, 0);
    chk("f5_rdB", ifb.fetchRdata, minit(32'h8));
    idle(3);

    // Simultaneous fetch and load: data wins, fetch follows.
    fetchReq = 1'b1; fetchAddr = 32'h10; load(32'h100); #3;
    chk("c0_dataGnt", ifa.dataGnt, 1);
    chk("c0_fetchGnt", ifa.fetchGnt, 0);
    chk("c0_stall", ifa.fetchStall, 1);
    chk("c0_memAddr", ifa.memAddr, 32'h100);
    nxt(); dataReq = 1'b0; #3;
    chk("c1_fetchGnt", ifa.fetchGnt, 1);
    nxt(); fetchReq = 1'b0; #3;
    chk("c2_drvA", ifa.dataRvalid, 1);
    chk("c2_ddA", ifa.dataRdata, minit(32'h100));
    chk("c2_frvA", ifa.fetchRvalid, 0);
    nxt(); #3;
    chk("c3_fdA", ifa.fetchRdata, minit(32'h10));
    chk("c3_ddB", ifb.dataRdata, minit(32'h100));
    idle(3);

    // Starvation bound: fetch wins on the 5th cycle and every 5th after.
    fetchReq = 1'b1; fetchAddr = 32'h20; load(32'h40);
    for (int i = 0; i < 10; i++) begin
      #3;
      chk($sformatf("starve%0d_fg", i), ifa.fetchGnt, (i == 4 || i == 9) ? 1 : 0);
      chk($sformatf("starve%0d_dg", i), ifa.dataGnt, (i == 4 || i == 9) ? 0 : 1);
      nxt();
    end
    idle(4);

    // Flush kills in-flight fetch reads.
    fetchReq = 1'b1; fetchAddr = 32'h30; nxt();
    fetchAddr = 32'h34; nxt();
    flush = 1'b1; #3;
    chk("fl2_fetchGnt", ifa.fetchGnt, 0);
    chk("fl2_stall", ifa.fetchStall, 1);
    chk("fl2_rvA", ifa.fetchRvalid, 0);
    nxt(); quiet(); #3;
    chk("fl3_rvA", ifa.fetchRvalid, 0);
    chk("fl3_rvB", ifb.fetchRvalid, 0);
    nxt(); #3;
    chk("fl4_rvB", ifb.fetchRvalid, 0);
    idle(3);

    // Flush leaves data reads alone; data granted in a flush cycle.
    fetchReq = 1'b1; fetchAddr = 32'h30; nxt();
    fetchReq = 1'b0; load(32'h44); #3;
    chk("fd1_dataGnt", ifa.dataGnt, 1);
    nxt(); flush = 1'b1; fetchReq = 1'b1; load(32'h48); #3;
    chk("fd2_dataGnt", ifa.dataGnt, 1);
    chk("fd2_fetchGnt", ifa.fetchGnt, 0);
    chk("fd2_frvA", ifa.fetchRvalid, 0);
    nxt(); quiet(); #3;
    chk("fd3_ddA", ifa.dataRdata, minit(32'h44));
    chk("fd3_frvB", ifb.fetchRvalid, 0);
    nxt(); #3;
    chk("fd4_ddB", ifb.dataRdata, minit(32'h44));
    chk("fd4_ddA", ifa.dataRdata, minit(32'h48));
    nxt(); #3;
    chk("fd5_ddB", ifb.dataRdata, minit(32'h48));
    idle(3);

    // Partial store followed by a load of the merged word.
    dataReq = 1'b1; dataWe = 1'b1; dataBe = 4'b0011; dataAddr = 32'h200;
    dataWdata = 32'hDEADBEEF; #3;
    chk("st_memWe", ifa.memWe, 1);
    chk("st_memBe", ifa.memBe, 4'b0011);
    chk("st_memWdata", ifa.memWdata, 32'hDEADBEEF);
    nxt(); load(32'h200); #3;
    chk("ld_memWe", ifa.memWe, 0);
    nxt(); quiet(); #3;
    chk("st_norvA", ifa.dataRvalid, 0);
    e = minit(32'h200);
    nxt(); #3;
    chk("ld_ddA", ifa.dataRdata, {e[31:16], 16'hBEEF});
    chk("ld_norvB", ifb.dataRvalid, 0);
    nxt(); #3;
    chk("ld_ddB", ifb.dataRdata, {e[31:16], 16'hBEEF});
    idle(3);

    // Asynchronous reset with reads in flight and a non-zero starve count.
    fetchReq = 1'b1; fetchAddr = 32'h50; load(32'h54); nxt();
    dataAddr = 32'h58; nxt();
    #3;
    chk("ar_pre_drvA", ifa.dataRvalid, 1);
    rst = 1'b1; #1;
    chk("ar_dataGnt", ifa.dataGnt, 0);
    chk("ar_stall", ifa.fetchStall, 0);
    chk("ar_memReq", ifa.memReq, 0);
    chk("ar_drvA", ifa.dataRvalid, 0);
    chk("ar_ddA", ifa.dataRdata, 0);
    @(posedge clk); @(negedge clk); rst = 1'b0; quiet();
    nxt();
    for (int i = 0; i < 3; i++) begin
      #3;
      chk($sformatf("ar%0d_rvA", i), {ifa.dataRvalid, ifa.fetchRvalid}, 0);
      chk($sformatf("ar%0d_rvB", i), {ifb.dataRvalid, ifb.fetchRvalid}, 0);
      nxt();
    end
    fetchReq = 1'b1; fetchAddr = 32'h60; load(32'h64);
    for (int i = 0; i < 5; i++) begin
      #3;
      chk($sformatf("ar_starve%0d", i), ifa.fetchGnt, (i == 4) ? 1 : 0);
      nxt();
    end
    idle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_mem_arbiter.md
Name: fetch_mem_arbiter

Overview:
- Shares one single-ported synchronous unified memory between two requesters: instruction fetch (PC stage: address, read enable, stall input) and the load/store unit.
- Issues at most one memory request per cycle.
- Tracks in-flight reads through a MEM_LAT-deep tag pipeline and routes read data back to the owner.
- Generates the fetch stall, discards fetch responses killed by a branch redirect, and bounds fetch starvation.

Parameters:
MEM_LAT, 1, memory read latency in cycles (legal 1..4); memRdata valid MEM_LAT cycles after the request cycle
STARVE_MAX, 4, consecutive denied fetch cycles before fetch takes priority over data (legal 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
fetchReq  in  1  fetch read request (PC stage read enable)
fetchAddr  in  32  fetch address (word aligned)
flush  in  1  branch redirect; kills in-flight fetch reads and blocks fetch grant this cycle
fetchGnt  out  1  fetch request issued to memory this cycle
fetchStall  out  1  fetchReq & !fetchGnt; holds the PC register
fetchRvalid  out  1  fetch read data valid
fetchRdata  out  32  fetch read data
dataReq  in  1  load/store request
dataWe  in  1  1 = store, 0 = load
dataBe  in  4  store byte enables
dataAddr  in  32  load/store address
dataWdata  in  32  store data
dataGnt  out  1  data request issued this cycle
dataRvalid  out  1  load data valid
dataRdata  out  32  load data
memReq  out  1  memory request strobe
memWe  out  1  memory write enable
memBe  out  4  memory byte enables
memAddr  out  32  memory address
memWdata  out  32  memory write data
memRdata  in  32  memory read data

Behaviour:
- Grant (combinational, same cycle):
  - fetchEligible = fetchReq & !flush & !rst.
  - If starveCnt == STARVE_MAX and fetchEligible: fetchGnt = 1, dataGnt = 0.
  - Otherwise dataGnt = dataReq; fetchGnt = fetchEligible & !dataReq.
  - fetchGnt and dataGnt are never both 1.
- Memory port:
  - memReq = fetchGnt | dataGnt.
  - Mux selects the granted requester's address, we, be, wdata.
  - Fetch drives memWe = 0, memBe = 4'hF, memWdata = 0.
  - No grant: all mem* outputs = 0.
- fetchStall = fetchReq & !fetchGnt, including flush cycles.
- Starvation counter (starveCnt, 4 bit, registered):
  - Cleared when fetchGnt = 1 or fetchReq = 0.
  - Otherwise increments by 1, saturating at STARVE_MAX.
  - Flush cycles with fetchReq = 1 do not increment.
- Tag pipeline:
  - MEM_LAT stages; each entry holds {valid, owner (0 = fetch, 1 = data)}.
  - Stage 0 loads valid = memReq & !memWe and the owner on each clock; entries shift one stage per cycle with no stalling.
  - Stores never create a valid entry.
- Response, combinational from the last stage:
  - fetchRvalid = tail.valid & owner == fetch; dataRvalid = tail.valid & owner == data.
  - Each rdata = memRdata when its rvalid = 1, else 0.
  - Fixed latency: read granted in cycle N returns in cycle N + MEM_LAT.
- Flush:
  - In a flush cycle, every fetch-owned entry currently in the pipeline is invalidated as it shifts.
  - If the tail is fetch-owned in the flush cycle, fetchRvalid is forced to 0 that same cycle.
  - Data entries are unaffected.
- Reset:
  - Asynchronous; clears all tag entries and starveCnt.
  - While rst = 1: all grants, rvalids, rdata, stall and mem* outputs are 0.
  - Reads in flight at reset assertion are dropped and never produce rvalid after reset release.
- Back-to-back: one request per cycle is sustained; MEM_LAT reads may be in flight at once with no bubbles.
- Simultaneous events:
  - Flush + dataReq: data is granted normally.
  - Flush + starvation-priority cycle: fetch is not granted and the counter holds.

Test Plan:
- Reset then fetchReq = 1 only, fetchAddr = 0x0,0x4,0x8 on consecutive cycles, MEM_LAT = 2 -> fetchGnt = 1 each cycle, fetchStall = 0, fetchRvalid high at cycles 2,3,4 with memory data for 0x0,0x4,0x8.
- fetchReq = 1 and a load at 0x100 in the same cycle -> dataGnt = 1, fetchGnt = 0, fetchStall = 1; dataRvalid after MEM_LAT cycles with mem[0x100]; fetch granted on the next cycle.
- dataReq held high for 10 cycles with fetchReq = 1, STARVE_MAX = 4 -> fetch denied 4 cycles, fetchGnt = 1 in cycle 5, starveCnt returns to 0, data resumes in cycle 6.
- MEM_LAT = 3, fetch reads issued in cycles 0,1; flush in cycle 2 -> no fetchRvalid in cycles 3,4.
  - Repeat with a data load in cycle 1 instead -> its dataRvalid arrives in cycle 4.
- Store dataWe = 1, dataBe = 4'b0011, addr 0x200 -> memWe = 1, memBe = 0011 for one cycle; no dataRvalid ever; subsequent load of 0x200 returns the merged data.
- Two reads in flight, rst asserted asynchronously mid-cycle -> all outputs 0 immediately; after release no rvalid appears and starveCnt = 0.
